// File: rtl/param_fir_filter_if.sv
// -----------------------------------------------------------------------------
// param_fir_filter_if
// Handshake and data bundle for param_fir_filter. clock and reset stay plain
// ports on the filter itself.
//
// Parameters : LENGTH, DATA_WIDTH, COEFF_WIDTH (must match the filter instance)
// Signals    :
//   load_coefficients_flag, start_flag, stop_flag   control requests
//   coefficient_valid / coefficient_in             coefficient stream
//   data_in_valid / data_in                        sample stream
//   coeff_ready, data_ready, coeffs_loaded         status
//   data_out_valid / data_out                      result stream
// Modports   : master (drives requests and streams), slave (the filter)
// -----------------------------------------------------------------------------
interface param_fir_filter_if #(
  parameter int LENGTH      = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8
);
  localparam int OUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH);

  logic                          load_coefficients_flag;
  logic                          start_flag;
  logic                          stop_flag;
  logic                          coefficient_valid;
  logic signed [COEFF_WIDTH-1:0] coefficient_in;
  logic                          data_in_valid;
  logic signed [DATA_WIDTH-1:0]  data_in;
  logic                          coeff_ready;
  logic                          data_ready;
  logic                          coeffs_loaded;
  logic                          data_out_valid;
  logic signed [OUT_WIDTH-1:0]   data_out;

  modport master (
    output load_coefficients_flag, start_flag, stop_flag,
    output coefficient_valid, coefficient_in, data_in_valid, data_in,
    input  coeff_ready, data_ready, coeffs_loaded, data_out_valid, data_out
  );

  modport slave (
    input  load_coefficients_flag, start_flag, stop_flag,
    input  coefficient_valid, coefficient_in, data_in_valid, data_in,
    output coeff_ready, data_ready, coeffs_loaded, data_out_valid, data_out
  );
endinterface

// File: rtl/param_fir_filter.sv
// -----------------------------------------------------------------------------
// param_fir_filter
// Direct-form FIR filter with a run-time loadable coefficient set.
//   IDLE       : waits for a load or start request
//   LOAD_COEFF : accepts LENGTH coefficients h[0..LENGTH-1], then back to IDLE
//   RUN        : each valid sample produces y[n] = sum h[k]*x[n-k]
// Arithmetic is full precision, so the result never wraps.
//
// Ports:
//   clock  - rising-edge system clock
//   reset  - synchronous, active-high; clears all state
//   bus    - param_fir_filter_if.slave (requests, coefficient/sample streams,
//            status flags, result stream)
//
// Build option:
//   FIR_PIPE_EN - when defined, a product register stage is inserted; result
//                 latency becomes 2 cycles instead of 1, throughput unchanged.
// -----------------------------------------------------------------------------
module param_fir_filter #(
  parameter int LENGTH      = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8
) (
  input logic                clock,
  input logic                reset,
  param_fir_filter_if.slave  bus
);
  localparam int OUT_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int CNT_WIDTH  = $clog2(LENGTH);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LOAD_COEFF = 2'd1;
  localparam logic [1:0] ST_RUN        = 2'd2;

  typedef logic signed [DATA_WIDTH-1:0]  sample_t;
  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef logic signed [PROD_WIDTH-1:0]  prod_t;
  typedef logic signed [OUT_WIDTH-1:0]   out_t;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 coeffs_loaded_q, coeffs_loaded_d;
  coeff_t               coeff_q [LENGTH];
  coeff_t               coeff_d [LENGTH];
  // Holds x[n-1] .. x[n-LENGTH+1]; the current sample comes straight from data_in.
  sample_t              delay_q [LENGTH-1];
  sample_t              delay_d [LENGTH-1];
  out_t                 data_out_q, data_out_d;
  logic                 data_out_valid_q, data_out_valid_d;

  logic                 sample_accept;
  prod_t                prod_d  [LENGTH];
  prod_t                sum_src [LENGTH];
  logic                 result_valid;
  out_t                 acc;

  // Both operands are sign-extended to the product width first, so the
  // multiply is exact.
  function automatic prod_t mul(input sample_t x, input coeff_t h);
    return prod_t'(x) * prod_t'(h);
  endfunction

  assign sample_accept = (state_q == ST_RUN) && bus.data_in_valid;

  // ---------------------------------------------------------------------------
  // Control FSM, coefficient store and delay line
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    coeffs_loaded_d = coeffs_loaded_q;
    coeff_d         = coeff_q;
    delay_d         = delay_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_coefficients_flag) begin
          state_d         = ST_LOAD_COEFF;
          cnt_d           = '0;
          coeffs_loaded_d = 1'b0;
        end else if (bus.start_flag && coeffs_loaded_q) begin
          state_d = ST_RUN;
          // A new run starts from silence; the coefficients are kept.
          for (int k = 0; k < LENGTH-1; k++) delay_d[k] = '0;
        end
      end

      ST_LOAD_COEFF: begin
        if (bus.coefficient_valid) begin
          coeff_d[cnt_q] = bus.coefficient_in;
          if (cnt_q == CNT_WIDTH'(LENGTH-1)) begin
            coeffs_loaded_d = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (bus.data_in_valid) begin
          delay_d[0] = bus.data_in;
          for (int k = 1; k < LENGTH-1; k++) delay_d[k] = delay_q[k-1];
        end
        // A sample taken together with stop is still shifted and filtered.
        if (bus.stop_flag) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Products for the sample being accepted this cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_d[0] = mul(bus.data_in, coeff_q[0]);
    for (int k = 1; k < LENGTH; k++) prod_d[k] = mul(delay_q[k-1], coeff_q[k]);
  end

`ifdef FIR_PIPE_EN
  prod_t prod_q [LENGTH];
  logic  prod_valid_q, prod_valid_d;

  assign prod_valid_d = sample_accept;

  // The product stage drains independently of the FSM so a result in flight
  // at stop still reaches data_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_valid_q <= 1'b0;
      for (int k = 0; k < LENGTH; k++) prod_q[k] <= '0;
    end else begin
      prod_valid_q <= prod_valid_d;
      if (sample_accept) prod_q <= prod_d;
    end
  end

  always_comb begin
    sum_src      = prod_q;
    result_valid = prod_valid_q;
  end
`else
  always_comb begin
    sum_src      = prod_d;
    result_valid = sample_accept;
  end
`endif

  // ---------------------------------------------------------------------------
  // Adder tree and output register; data_out holds between strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    acc = '0;
    for (int k = 0; k < LENGTH; k++) acc = acc + out_t'(sum_src[k]);
    data_out_valid_d = result_valid;
    data_out_d       = result_valid ? acc : data_out_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      coeffs_loaded_q  <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      // NOTE: the coefficient and delay arrays are reset on purpose: a reset
      // must leave no stale taps behind. This forces them into flops rather
      // than RAM, which is fine at these sizes.
      for (int k = 0; k < LENGTH; k++)   coeff_q[k] <= '0;
      for (int k = 0; k < LENGTH-1; k++) delay_q[k] <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      coeffs_loaded_q  <= coeffs_loaded_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      coeff_q          <= coeff_d;
      delay_q          <= delay_d;
    end
  end

  assign bus.coeff_ready    = (state_q == ST_LOAD_COEFF);
  assign bus.data_ready     = (state_q == ST_RUN);
  assign bus.coeffs_loaded  = coeffs_loaded_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.data_out       = data_out_q;
endmodule

// File: tb/tb_param_fir_filter.sv
// -----------------------------------------------------------------------------
// tb_param_fir_filter
// Directed bench for param_fir_filter at default parameters. Inputs change on
// the falling edge; a monitor samples outputs 1 time unit after each rising
// edge and records every strobe with its cycle number so that values and
// latency can both be compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_param_fir_filter;
  localparam int LENGTH = 10;
  localparam int DW     = 8;
  localparam int CW     = 8;
`ifdef FIR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int   coef [LENGTH];
  int   exp_q[$];
  int   drv_cyc_q[$];
  int   out_q[$];
  int   out_cyc_q[$];
  int   last_out  = 0;
  int   hold_viol = 0;

  param_fir_filter_if #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

  param_fir_filter #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: records strobes, and flags data_out moving without one.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      last_out = int'(bus.data_out);
    end else if (bus.data_out_valid) begin
      out_q.push_back(int'(bus.data_out));
      out_cyc_q.push_back(cyc);
      last_out = int'(bus.data_out);
    end else if (int'(bus.data_out) != last_out) begin
      hold_viol++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_capture();
    out_q.delete();
    out_cyc_q.delete();
    exp_q.delete();
    drv_cyc_q.delete();
    hold_viol = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_sample(input int v);
    @(negedge clock);
    bus.data_in_valid = 1'b1;
    bus.data_in       = DW'(v);
    drv_cyc_q.push_back(cyc);
  endtask

  task automatic end_samples();
    @(negedge clock);
    bus.data_in_valid = 1'b0;
  endtask

  // Full load with a one-cycle coefficient_valid gap carrying a junk value,
  // followed by one surplus coefficient that must be ignored.
  task automatic load_coeffs(input string name);
    @(negedge clock);
    bus.load_coefficients_flag = 1'b1;
    @(negedge clock);
    bus.load_coefficients_flag = 1'b0;
    total++;
    if (bus.coeff_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s coeff_ready in load: got %b want 1", name, bus.coeff_ready);
    end
    total++;
    if (bus.coeffs_loaded !== 1'b0) begin
      bad++;
      $display("FAIL %s coeffs_loaded in load: got %b want 0", name, bus.coeffs_loaded);
    end
    for (int k = 0; k < LENGTH; k++) begin
      if (k == 4) begin
        bus.coefficient_valid = 1'b0;
        bus.coefficient_in    = CW'(99);
        @(negedge clock);
      end
      bus.coefficient_valid = 1'b1;
      bus.coefficient_in    = CW'(coef[k]);
      @(negedge clock);
    end
    total++;
    if (bus.coeffs_loaded !== 1'b1) begin
      bad++;
      $display("FAIL %s coeffs_loaded after load: got %b want 1", name, bus.coeffs_loaded);
    end
    total++;
    if (bus.coeff_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s coeff_ready after load: got %b want 0", name, bus.coeff_ready);
    end
    bus.coefficient_in = CW'(77);
    @(negedge clock);
    bus.coefficient_valid = 1'b0;
  endtask

  task automatic start_run(input string name, input logic exp_ready);
    @(negedge clock);
    bus.start_flag = 1'b1;
    @(negedge clock);
    bus.start_flag = 1'b0;
    total++;
    if (bus.data_ready !== exp_ready) begin
      bad++;
      $display("FAIL %s data_ready after start: got %b want %b", name, bus.data_ready, exp_ready);
    end
  endtask

  task automatic stop_run(input string name, input logic with_sample, input int v);
    @(negedge clock);
    bus.stop_flag = 1'b1;
    if (with_sample) begin
      bus.data_in_valid = 1'b1;
      bus.data_in       = DW'(v);
      drv_cyc_q.push_back(cyc);
    end
    @(negedge clock);
    bus.stop_flag     = 1'b0;
    bus.data_in_valid = 1'b0;
    total++;
    if (bus.data_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s data_ready after stop: got %b want 0", name, bus.data_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    total++;
    if (bus.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL reset coeffs_loaded: got %b want 0", bus.coeffs_loaded); end
    total++;
    if (bus.coeff_ready !== 1'b0) begin bad++; $display("FAIL reset coeff_ready: got %b want 0", bus.coeff_ready); end
    total++;
    if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset data_ready: got %b want 0", bus.data_ready); end
    total++;
    if (bus.data_out_valid !== 1'b0) begin bad++; $display("FAIL reset data_out_valid: got %b want 0", bus.data_out_valid); end
    total++;
    if (bus.data_out !== '0) begin bad++; $display("FAIL reset data_out: got %0d want 0", bus.data_out); end
  endtask

  // h = 1..10, one impulse then zeros, all back to back.
  task automatic test_impulse();
    for (int k = 0; k < LENGTH; k++) coef[k] = k + 1;
    load_coeffs("impulse");
    start_run("impulse", 1'b1);
    clear_capture();
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0};
    drive_sample(1);
    repeat (11) drive_sample(0);
    end_samples();
    idle(4);
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL impulse strobe count: got %0d want %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL impulse y[%0d]: got %0d want %0d", i, out_q[i], exp_q[i]); end
      total++;
      if (out_cyc_q[i] - drv_cyc_q[i] !== LAT) begin
        bad++;
        $display("FAIL impulse latency[%0d]: got %0d want %0d", i, out_cyc_q[i] - drv_cyc_q[i], LAT);
      end
    end
    total++;
    if (hold_viol != 0) begin bad++; $display("FAIL impulse data_out hold: got %0d changes want 0", hold_viol); end
  endtask

  // Stop with a final sample, try a sample outside RUN, restart: delay line
  // cleared (1, not 1*1 + 7*2), coefficients kept.
  task automatic test_stop_restart();
    clear_capture();
    exp_q = '{7, 1};
    stop_run("stop", 1'b1, 7);
    @(negedge clock);
    bus.data_in_valid = 1'b1;
    bus.data_in       = DW'(50);
    @(negedge clock);
    bus.data_in_valid = 1'b0;
    start_run("restart", 1'b1);
    drive_sample(1);
    end_samples();
    idle(4);
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL restart strobe count: got %0d want %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart y[%0d]: got %0d want %0d", i, out_q[i], exp_q[i]); end
      total++;
      if (out_cyc_q[i] - drv_cyc_q[i] !== LAT) begin
        bad++;
        $display("FAIL restart latency[%0d]: got %0d want %0d", i, out_cyc_q[i] - drv_cyc_q[i], LAT);
      end
    end
    total++;
    if (hold_viol != 0) begin bad++; $display("FAIL restart data_out hold: got %0d changes want 0", hold_viol); end
  endtask

  // h all 1, constant 5 with two idle gaps: running sum saturating at 50.
  task automatic test_ones();
    stop_run("ones", 1'b0, 0);
    for (int k = 0; k < LENGTH; k++) coef[k] = 1;
    load_coeffs("ones");
    start_run("ones", 1'b1);
    clear_capture();
    exp_q = '{5, 10, 15, 20, 25, 30, 35, 40, 45, 50, 50, 50};
    for (int i = 0; i < 12; i++) begin
      if (i == 4 || i == 8) begin
        @(negedge clock);
        bus.data_in_valid = 1'b0;
      end
      drive_sample(5);
    end
    end_samples();
    idle(4);
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL ones strobe count: got %0d want %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL ones y[%0d]: got %0d want %0d", i, out_q[i], exp_q[i]); end
      total++;
      if (out_cyc_q[i] - drv_cyc_q[i] !== LAT) begin
        bad++;
        $display("FAIL ones latency[%0d]: got %0d want %0d", i, out_cyc_q[i] - drv_cyc_q[i], LAT);
      end
    end
    total++;
    if (hold_viol != 0) begin bad++; $display("FAIL ones data_out hold: got %0d changes want 0", hold_viol); end
  endtask

  // Most negative operands everywhere: 16384 per tap, 163840 at the tenth.
  task automatic test_extreme();
    stop_run("extreme", 1'b0, 0);
    for (int k = 0; k < LENGTH; k++) coef[k] = -128;
    load_coeffs("extreme");
    start_run("extreme", 1'b1);
    clear_capture();
    exp_q = '{16384, 32768, 49152, 65536, 81920, 98304, 114688, 131072, 147456, 163840};
    repeat (10) drive_sample(-128);
    end_samples();
    idle(4);
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL extreme strobe count: got %0d want %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total++;
      if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL extreme y[%0d]: got %0d want %0d", i, out_q[i], exp_q[i]); end
      total++;
      if (out_cyc_q[i] - drv_cyc_q[i] !== LAT) begin
        bad++;
        $display("FAIL extreme latency[%0d]: got %0d want %0d", i, out_cyc_q[i] - drv_cyc_q[i], LAT);
      end
    end
  endtask

  // Reset after four coefficients, asserted together with a coefficient and
  // a start request; afterwards start must be refused and nothing emitted.
  task automatic test_reset_midload();
    stop_run("midload", 1'b0, 0);
    @(negedge clock);
    bus.load_coefficients_flag = 1'b1;
    @(negedge clock);
    bus.load_coefficients_flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.coefficient_valid = 1'b1;
      bus.coefficient_in    = CW'(k + 1);
      @(negedge clock);
    end
    reset              = 1'b1;
    bus.coefficient_in = CW'(5);
    bus.start_flag     = 1'b1;
    @(negedge clock);
    reset                 = 1'b0;
    bus.coefficient_valid = 1'b0;
    bus.start_flag        = 1'b0;
    total++;
    if (bus.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL midload coeffs_loaded: got %b want 0", bus.coeffs_loaded); end
    total++;
    if (bus.coeff_ready !== 1'b0) begin bad++; $display("FAIL midload coeff_ready: got %b want 0", bus.coeff_ready); end
    total++;
    if (bus.data_out !== '0) begin bad++; $display("FAIL midload data_out: got %0d want 0", bus.data_out); end
    clear_capture();
    start_run("midload", 1'b0);
    repeat (3) drive_sample(9);
    end_samples();
    idle(3);
    total++;
    if (out_q.size() != 0) begin bad++; $display("FAIL midload strobes: got %0d want 0", out_q.size()); end
    total++;
    if (bus.data_out !== '0) begin bad++; $display("FAIL midload data_out after start: got %0d want 0", bus.data_out); end
  endtask

  initial begin
    bus.load_coefficients_flag = 1'b0;
    bus.start_flag             = 1'b0;
    bus.stop_flag              = 1'b0;
    bus.coefficient_valid      = 1'b0;
    bus.coefficient_in         = '0;
    bus.data_in_valid          = 1'b0;
    bus.data_in                = '0;

    test_reset();
    test_impulse();
    test_stop_restart();
    test_ones();
    test_extreme();
    test_reset_midload();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/param_fir_filter.md
PARAM_FIR_FILTER -- requirements
Module: param_fir_filter

Interface
- REQ-001 SHALL: parameter LENGTH, default 10, number of taps (>=2).
- REQ-002 SHALL: parameter DATA_WIDTH, default 8, signed input sample width.
- REQ-003 SHALL: parameter COEFF_WIDTH, default 8, signed coefficient width.
- REQ-004 SHALL: localparam OUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH), 20 at defaults.
- REQ-005 SHALL: clock  input  1  single system clock; all logic on its rising edge.
- REQ-006 SHALL: reset  input  1  synchronous, active-high reset.
- REQ-007 SHALL: load_coefficients_flag  input  1  request a coefficient load, sampled in IDLE.
- REQ-008 SHALL: start_flag  input  1  request filtering, sampled in IDLE.
- REQ-009 SHALL: stop_flag  input  1  end filtering, sampled in RUN.
- REQ-010 SHALL: coefficient_valid  input  1  coefficient_in qualifier.
- REQ-011 SHALL: coefficient_in  input  COEFF_WIDTH  signed coefficient.
- REQ-012 SHALL: data_in_valid  input  1  data_in qualifier.
- REQ-013 SHALL: data_in  input  DATA_WIDTH  signed sample.
- REQ-014 SHALL: coeff_ready  output  1  high in LOAD_COEFF.
- REQ-015 SHALL: data_ready  output  1  high in RUN.
- REQ-016 SHALL: coeffs_loaded  output  1  full coefficient set held.
- REQ-017 SHALL: data_out_valid  output  1  one-cycle strobe per result.
- REQ-018 SHALL: data_out  output  OUT_WIDTH  signed filter result, held between strobes.

Function
- REQ-019 SHALL: FSM states IDLE, LOAD_COEFF, RUN.
- REQ-020 SHALL: IDLE -> LOAD_COEFF on load_coefficients_flag; else IDLE -> RUN on start_flag with coeffs_loaded=1; start_flag ignored when coeffs_loaded=0.
- REQ-021 SHALL: entering LOAD_COEFF clears coeffs_loaded and the coefficient counter.
- REQ-022 SHALL: in LOAD_COEFF, k-th accepted coefficient (coefficient_valid=1, k=0..LENGTH-1) stored as h[k]; cycles with coefficient_valid=0 hold state.
- REQ-023 SHALL: on acceptance of h[LENGTH-1], set coeffs_loaded=1 and go to IDLE next cycle; no extra coefficients accepted.
- REQ-024 SHALL: in RUN, each data_in_valid=1 cycle shifts data_in into the delay line as x[n]; result y[n] = sum over k=0..LENGTH-1 of h[k]*x[n-k], current sample included.
- REQ-025 SHALL: data_in_valid=0 in RUN leaves delay line and data_out unchanged, no strobe.
- REQ-026 SHALL: products full-precision signed (DATA_WIDTH+COEFF_WIDTH bits), accumulated sign-extended at OUT_WIDTH; no truncation, overflow impossible.
- REQ-027 SHALL: latency from accepted sample to data_out_valid is 1 cycle (macro off); back-to-back samples give back-to-back results.
- REQ-028 SHALL: stop_flag in RUN -> IDLE next cycle; a sample accepted in the same cycle is processed and its result still emitted, including in-flight pipeline results.
- REQ-029 SHALL: delay line cleared to zero on every entry to RUN; coefficients retained across stop/start.
- REQ-030 SHALL: data_in_valid outside RUN and coefficient_valid outside LOAD_COEFF ignored.

Reset
- REQ-031 SHALL: reset forces IDLE, clears coefficients, delay line, counter, pipeline registers; coeffs_loaded, coeff_ready, data_ready, data_out_valid, data_out = 0 the cycle after.
- REQ-032 SHALL: reset mid-load or mid-run takes priority over every other input; in-flight results discarded.

Configuration
- REQ-033 SHALL: macro FIR_PIPE_EN defined inserts a product register stage, latency 2 cycles, identical results and throughput; undefined gives latency 1 cycle.

Verification
- REQ-034 SHALL: load h=1..10, start, samples 1,0x12 -> data_out 1,2,...,10,0,0 on consecutive strobes.
- REQ-035 SHALL: h all 1, samples 5 x12 -> outputs 5,10,...,50,50,50.
- REQ-036 SHALL: h all -128, samples -128 x10 -> tenth output 163840, no wrap.
- REQ-037 SHALL: stop with sample 7 after impulse test, restart, sample 1 -> first output 1 (delay line cleared, h kept).
- REQ-038 SHALL: reset after 4 coefficients -> coeffs_loaded=0, start_flag ignored, outputs 0.
- REQ-039 SHALL: repeat REQ-034 with FIR_PIPE_EN -> same values, data_out_valid 2 cycles after each sample.
